// File: rtl/squeeze_weight_sequencer.sv
// squeeze_weight_sequencer
//   Sequences the 1x1 squeeze weight ROM array and its MAC lanes for one layer
//   pass. Every input channel (one ROM address per channel) is walked for every
//   output pixel. Each finished pixel is then handed to the writeback stage.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start                1-cycle pass request (honoured only in IDLE)
//     busy, done           pass in progress / 1-cycle end-of-pass pulse
//     rom_addr, pix_idx    registered channel index / output pixel index
//     mac_en, mac_ready    weight-valid handshake towards the MAC lanes
//     acc_clr, acc_last    first / last channel markers (qualified by mac_en)
//     res_valid, res_ready result handshake towards writeback
//     stall_cnt            only when SQZ_SEQ_PERF_EN is defined: saturating count
//                          of RUN cycles without mac_ready plus FLUSH cycles
//                          without res_ready
//
//   Optional feature macro: SQZ_SEQ_PERF_EN
module squeeze_weight_sequencer #(
  parameter int ADDR   = 9,
  parameter int CIN    = 384,
  parameter int PIXELS = 169,
  parameter int PIX_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [ADDR-1:0]  rom_addr,
  output logic [PIX_W-1:0] pix_idx,
  output logic             mac_en,
  input  logic             mac_ready,
  output logic             acc_clr,
  output logic             acc_last,
  output logic             res_valid,
  input  logic             res_ready
`ifdef SQZ_SEQ_PERF_EN
  ,output logic [31:0]     stall_cnt
`endif
);

  // Reject configurations the counters cannot represent.
  if (CIN < 1 || CIN > (1 << ADDR) || PIXELS < 1 || PIXELS > (1 << PIX_W)) begin : g_param_err
    $error("squeeze_weight_sequencer: illegal CIN/PIXELS for ADDR/PIX_W");
  end

  localparam logic [ADDR-1:0]  CH_LAST  = ADDR'(CIN - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  ch_q, ch_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mac_en_q, mac_en_d;
  logic             acc_clr_q, acc_clr_d;
  logic             acc_last_q, acc_last_d;
  logic             res_valid_q, res_valid_d;

  // Next-state and next-output computation; outputs are decoded from the
  // next state so every output leaves the block straight from a flop.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ch_d    = {ADDR{1'b0}};
          pix_d   = {PIX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // mac_en is always high in RUN, so a step is just mac_ready.
        if (mac_ready) begin
          if (ch_q == CH_LAST) begin
            ch_d    = {ADDR{1'b0}};
            state_d = S_FLUSH;
          end else begin
            ch_d    = ch_q + ADDR'(1);
          end
        end else begin
          ch_d = ch_q;
        end
      end
      S_FLUSH: begin
        if (res_ready) begin
          if (pix_q == PIX_LAST) begin
            pix_d   = {PIX_W{1'b0}};
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            pix_d   = pix_q + PIX_W'(1);
            state_d = S_RUN;
          end
        end else begin
          pix_d = pix_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = {ADDR{1'b0}};
        pix_d   = {PIX_W{1'b0}};
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    mac_en_d    = (state_d == S_RUN);
    acc_clr_d   = (state_d == S_RUN) && (ch_d == {ADDR{1'b0}});
    acc_last_d  = (state_d == S_RUN) && (ch_d == CH_LAST);
    res_valid_d = (state_d == S_FLUSH);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= {ADDR{1'b0}};
      pix_q       <= {PIX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      acc_last_q  <= acc_last_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = ch_q;
  assign pix_idx   = pix_q;
  assign mac_en    = mac_en_q;
  assign acc_clr   = acc_clr_q;
  assign acc_last  = acc_last_q;
  assign res_valid = res_valid_q;

`ifdef SQZ_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: cleared by an accepted start, saturating, held after done.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) begin
      stall_cnt_d = 32'd0;
    end else if (((state_q == S_RUN && !mac_ready) || (state_q == S_FLUSH && !res_ready))
                 && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
